// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared encodings and helpers for the LED pattern engine
package led_pattern_pkg;

  typedef enum logic [3:0] {
    MODE_OFF      = 4'd0,
    MODE_ON       = 4'd1,
    MODE_ROT_UP   = 4'd2,
    MODE_ROT_DN   = 4'd3,
    MODE_BLINK    = 4'd4,
    MODE_CONVERGE = 4'd5,
    MODE_BOUNCE   = 4'd6,
    MODE_BREATHE  = 4'd7
  } mode_e;

  localparam logic [1:0] SPEED_X1 = 2'd0;
  localparam logic [1:0] SPEED_X2 = 2'd1;
  localparam logic [1:0] SPEED_X4 = 2'd2;
  localparam logic [1:0] SPEED_X8 = 2'd3;

  // Counter width able to hold 0..div-1.
  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing a one-cycle tick every (DIV >> speed) clocks
module led_tick_gen
  import led_pattern_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic       enable,
  input  logic       clear,
  output logic       tick
);

  localparam int W = div_width(DIV);

  logic [W-1:0] cnt;
  logic [W-1:0] last;

  // Terminal count for the current speed; a divider shifted down to 0 or 1 ticks every cycle.
  always_comb begin
    last = '0;
    if ((DIV >> speed) > 1) last = W'((DIV >> speed) - 1);
  end

  // >= so that raising the speed mid-count fires immediately instead of wrapping the counter.
  assign tick = enable && !clear && (cnt >= last);

  // Count while enabled, restart after each tick or on an explicit clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - switch-selected LED pattern engine with prescaled stepping and PWM breathing
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int LED_N      = 8,
  parameter int TICK_DIV   = 6_250_000,
  parameter int BREATH_DIV = 195_312,
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sw,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [LED_N-1:0] led
);

  localparam int PW = $clog2(LED_N);
  localparam int H  = (LED_N + 1) / 2;
  localparam int FW = $clog2(2 * H);

  localparam logic [PW-1:0]       POS_MAX   = PW'(LED_N - 1);
  localparam logic [FW-1:0]       FRAME_MAX = FW'(2 * H - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [LED_N-1:0]    DARK      = {LED_N{ACTIVE_LOW != 0}};

  logic [3:0] sw_s1, sw_s2;
  logic [1:0] speed_s1, speed_s2;
  logic       pause_s1, pause_s2;

  logic [3:0]          mode;
  logic [PW-1:0]       pos, pos_n;
  logic                bounce_down, bounce_down_n;
  logic [FW-1:0]       frame, frame_n;
  logic [PWM_BITS-1:0] duty, duty_n;
  logic                breath_down, breath_down_n;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_n;

  logic             mode_chg;
  logic             step_tick;
  logic             breath_tick;
  logic [LED_N-1:0] raw;
  int               cov;

  // Two-flop synchronisers for the switch-driven controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      speed_s1 <= '0;
      speed_s2 <= '0;
      pause_s1 <= 1'b0;
      pause_s2 <= 1'b0;
    end else begin
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      speed_s1 <= speed;
      speed_s2 <= speed_s1;
      pause_s1 <= pause;
      pause_s2 <= pause_s1;
    end
  end

  assign mode_chg = (sw_s2 != mode);

  led_tick_gen #(.DIV(TICK_DIV)) u_step_tick (
    .clk    (clk),
    .rst    (rst),
    .speed  (speed_s2),
    .enable (!pause_s2),
    .clear  (mode_chg),
    .tick   (step_tick)
  );

  led_tick_gen #(.DIV(BREATH_DIV)) u_breath_tick (
    .clk    (clk),
    .rst    (rst),
    .speed  (speed_s2),
    .enable (!pause_s2),
    .clear  (mode_chg),
    .tick   (breath_tick)
  );

  // Next pattern state: a mode change restarts everything, otherwise advance on ticks unless paused.
  always_comb begin
    pos_n         = pos;
    bounce_down_n = bounce_down;
    frame_n       = frame;
    duty_n        = duty;
    breath_down_n = breath_down;
    pwm_n         = pwm_cnt + PWM_BITS'(1);
    if (mode_chg) begin
      pos_n         = '0;
      bounce_down_n = 1'b0;
      frame_n       = '0;
      duty_n        = '0;
      breath_down_n = 1'b0;
    end else if (!pause_s2) begin
      case (mode)
        MODE_ROT_UP, MODE_ROT_DN: begin
          if (step_tick) pos_n = (pos == POS_MAX) ? '0 : pos + PW'(1);
        end
        MODE_BLINK: begin
          if (step_tick) frame_n = frame ^ FW'(1);
        end
        MODE_CONVERGE: begin
          if (step_tick) frame_n = (frame == FRAME_MAX) ? '0 : frame + FW'(1);
        end
        MODE_BOUNCE: begin
          if (step_tick) begin
            if (!bounce_down) begin
              if (pos == POS_MAX) begin
                bounce_down_n = 1'b1;
                pos_n         = pos - PW'(1);
              end else begin
                pos_n = pos + PW'(1);
              end
            end else begin
              if (pos == '0) begin
                bounce_down_n = 1'b0;
                pos_n         = pos + PW'(1);
              end else begin
                pos_n = pos - PW'(1);
              end
            end
          end
        end
        MODE_BREATHE: begin
          if (breath_tick) begin
            if (!breath_down) begin
              if (duty == DUTY_MAX) begin
                breath_down_n = 1'b1;
                duty_n        = duty - PWM_BITS'(1);
              end else begin
                duty_n = duty + PWM_BITS'(1);
              end
            end else begin
              if (duty == '0) begin
                breath_down_n = 1'b0;
                duty_n        = duty + PWM_BITS'(1);
              end else begin
                duty_n = duty - PWM_BITS'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Raw frame from the next state so the led register shows a new mode with no extra lag.
  always_comb begin
    raw = '0;
    cov = (int'(frame_n) < H) ? int'(frame_n) + 1 : 2 * H - 1 - int'(frame_n);
    case (sw_s2)
      MODE_ON:       raw = '1;
      MODE_ROT_UP:   raw[pos_n] = 1'b1;
      MODE_ROT_DN:   raw[POS_MAX - pos_n] = 1'b1;
      MODE_BLINK:    raw = {LED_N{frame_n[0]}};
      MODE_CONVERGE: begin
        for (int i = 0; i < LED_N; i++) raw[i] = (i < cov) || (i >= LED_N - cov);
      end
      MODE_BOUNCE:   raw[pos_n] = 1'b1;
      MODE_BREATHE:  raw = {LED_N{pwm_n < duty_n}};
      default:       raw = '0;
    endcase
  end

  // Pattern state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode        <= '0;
      pos         <= '0;
      bounce_down <= 1'b0;
      frame       <= '0;
      duty        <= '0;
      breath_down <= 1'b0;
      pwm_cnt     <= '0;
    end else begin
      mode        <= sw_s2;
      pos         <= pos_n;
      bounce_down <= bounce_down_n;
      frame       <= frame_n;
      duty        <= duty_n;
      breath_down <= breath_down_n;
      pwm_cnt     <= pwm_n;
    end
  end

  // Registered LED drive with optional inversion for active-low pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= DARK;
    else     led <= raw ^ DARK;
  end

endmodule
